// File: rtl/mem_req_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory bus, one outstanding
// transaction. Define ARB_ROUND_ROBIN_EN to alternate contested grants instead of data priority.
module mem_req_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          inst_req,
   input  logic [AW-1:0] inst_addr,
   output logic [DW-1:0] inst_rdata,
   output logic          i_stall,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [3:0]    data_wen,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic [DW-1:0] data_rdata,
   output logic          d_stall,
   input  logic          longest_stall,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [3:0]    mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StAddr, StWait} stateT;

   stateT         stateQ, stateD;
   logic          doneIQ, doneDQ;
   logic          grantDataQ;
   logic          memWrQ;
   logic [3:0]    memWenQ;
   logic [AW-1:0] memAddrQ;
   logic [DW-1:0] memWdataQ;
   logic [DW-1:0] instRdataQ, dataRdataQ;
   logic          pendI, pendD, pickData, latch, complete;

   assign pendI = inst_req & ~doneIQ;
   assign pendD = data_req & ~doneDQ;

`ifdef ARB_ROUND_ROBIN_EN
   logic lastDataQ;

   // Only contested grants move the pointer, so an uncontested grant never costs the other port.
   assign pickData = pendD & (~pendI | ~lastDataQ);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lastDataQ <= 1'b0;
      end else if (latch && pendI && pendD) begin
         lastDataQ <= pickData;
      end
   end
`else
   assign pickData = pendD;
`endif

   always_comb begin
      stateD   = stateQ;
      latch    = 1'b0;
      complete = 1'b0;
      case (stateQ)
         StIdle: begin
            if (pendI || pendD) begin
               stateD = StAddr;
               latch  = 1'b1;
            end
         end
         StAddr: begin
            if (mem_addr_ok) begin
               if (mem_data_ok) begin
                  stateD   = StIdle;
                  complete = 1'b1;
               end else begin
                  stateD = StWait;
               end
            end
         end
         StWait: begin
            if (mem_data_ok) begin
               stateD   = StIdle;
               complete = 1'b1;
            end
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   // A pipeline advance clears both flags even if a completion lands on the same edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         doneIQ <= 1'b0;
         doneDQ <= 1'b0;
      end else if (!longest_stall) begin
         doneIQ <= 1'b0;
         doneDQ <= 1'b0;
      end else if (complete) begin
         if (grantDataQ) begin
            doneDQ <= 1'b1;
         end else begin
            doneIQ <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grantDataQ <= 1'b0;
         memWrQ     <= 1'b0;
         memWenQ    <= 4'b0;
         memAddrQ   <= '0;
         memWdataQ  <= '0;
      end else if (latch) begin
         grantDataQ <= pickData;
         memWrQ     <= pickData & data_wr;
         memWenQ    <= pickData ? data_wen : 4'b0;
         memAddrQ   <= pickData ? data_addr : inst_addr;
         memWdataQ  <= pickData ? data_wdata : '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         instRdataQ <= '0;
         dataRdataQ <= '0;
      end else if (complete) begin
         if (grantDataQ) begin
            dataRdataQ <= mem_rdata;
         end else begin
            instRdataQ <= mem_rdata;
         end
      end
   end

   assign mem_req    = (stateQ == StAddr);
   assign mem_wr     = memWrQ;
   assign mem_wen    = memWenQ;
   assign mem_addr   = memAddrQ;
   assign mem_wdata  = memWdataQ;
   assign inst_rdata = instRdataQ;
   assign data_rdata = dataRdataQ;
   assign i_stall    = inst_req & ~doneIQ;
   assign d_stall    = data_req & ~doneDQ;

endmodule
